axi3_burst_addr_gen: RTL and testbench



---
 rtl/axi3_burst_addr_gen.sv | 185 ++++++++++++++++++
 tb/tb_axi3_burst_addr_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi3_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : axi3_burst_addr_gen
// Description : AXI3 burst address generator. It accepts one command and emits
//               one registered beat descriptor per data beat. It supports the
//               FIXED, INCR and WRAP burst types.
//               Optional macro AXI3_BURST_ADDR_GEN_4K_CHECK_EN flags any INCR
//               burst that crosses a 4 KB page.
// Revision    : 1.0 - initial release
// ============================================================================
module axi3_burst_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [3:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_burst,
    output logic                  beat_valid,
    input  logic                  beat_ready,
    output logic [ID_WIDTH-1:0]   beat_id,
    output logic [ADDR_WIDTH-1:0] beat_addr,
    output logic [3:0]            beat_idx,
    output logic                  beat_last,
    output logic                  beat_err
);

    localparam logic [0:0]            c_ST_IDLE    = 1'b0;
    localparam logic [0:0]            c_ST_BURST   = 1'b1;
    localparam logic [1:0]            c_MODE_FIXED = 2'd0;
    localparam logic [1:0]            c_MODE_INCR  = 2'd1;
    localparam logic [1:0]            c_MODE_WRAP  = 2'd2;
    localparam logic [2:0]            c_MAX_SIZE   = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [ADDR_WIDTH-1:0] c_ONE        = ADDR_WIDTH'(1);

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic                  r_valid;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_idx;
    logic                  r_last;
    logic                  r_err;
    logic [3:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_mode;
    logic [ADDR_WIDTH-1:0] r_wrap_lower;
    logic [ADDR_WIDTH-1:0] r_wrap_span;

    logic                  w_beat_fire;
    logic                  w_cmd_ready;
    logic                  w_cmd_fire;
    logic [ADDR_WIDTH-1:0] w_cmd_bytes;
    logic [ADDR_WIDTH-1:0] w_cmd_aligned;
    logic [ADDR_WIDTH-1:0] w_cmd_span;
    logic                  w_wrap_ok;
    logic                  w_size_err;
    logic                  w_page_err;
    logic                  w_cmd_err;
    logic [1:0]            w_cmd_mode;
    logic [ADDR_WIDTH-1:0] w_bytes;
    logic [ADDR_WIDTH-1:0] w_incr;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;

    assign w_beat_fire = r_valid & beat_ready;
    assign w_cmd_ready = ~rst & ((r_state == c_ST_IDLE) | (w_beat_fire & r_last));
    assign w_cmd_fire  = cmd_valid & w_cmd_ready;

    // Command decode: beat size, burst span and legality
    assign w_cmd_bytes   = c_ONE << cmd_size;
    assign w_cmd_aligned = cmd_addr & ~(w_cmd_bytes - c_ONE);
    assign w_cmd_span    = (ADDR_WIDTH'(cmd_len) + c_ONE) << cmd_size;
    assign w_wrap_ok     = ((cmd_len == 4'd1) | (cmd_len == 4'd3) | (cmd_len == 4'd7) |
                            (cmd_len == 4'd15)) & ((cmd_addr & (w_cmd_bytes - c_ONE)) == '0);
    assign w_size_err    = cmd_size > c_MAX_SIZE;

`ifdef AXI3_BURST_ADDR_GEN_4K_CHECK_EN
    assign w_page_err = (cmd_burst == 2'b01) &
                        (((w_cmd_aligned + w_cmd_span - c_ONE) >> 12) != (w_cmd_aligned >> 12));
`else
    assign w_page_err = 1'b0;
`endif

    assign w_cmd_err = (cmd_burst == 2'b11) | ((cmd_burst == 2'b10) & ~w_wrap_ok) |
                       w_size_err | w_page_err;

    // Illegal WRAP and reserved bursts fall back to INCR addressing
    always_comb begin
        w_cmd_mode = c_MODE_INCR;
        if (cmd_burst == 2'b00) begin
            w_cmd_mode = c_MODE_FIXED;
        end else if ((cmd_burst == 2'b10) && w_wrap_ok) begin
            w_cmd_mode = c_MODE_WRAP;
        end
    end

    assign w_bytes = c_ONE << r_size;
    assign w_incr  = (r_addr & ~(w_bytes - c_ONE)) + w_bytes;

    always_comb begin
        w_addr_nxt = w_incr;
        case (r_mode)
            c_MODE_FIXED: w_addr_nxt = r_addr;
            c_MODE_WRAP: begin
                if (w_incr == (r_wrap_lower + r_wrap_span)) begin
                    w_addr_nxt = r_wrap_lower;
                end
            end
            default: w_addr_nxt = w_incr;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_cmd_fire) begin
                    w_state_nxt = c_ST_BURST;
                end
            end
            c_ST_BURST: begin
                if (w_beat_fire && r_last && !w_cmd_fire) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_valid      <= 1'b0;
            r_id         <= '0;
            r_addr       <= '0;
            r_idx        <= 4'd0;
            r_last       <= 1'b0;
            r_err        <= 1'b0;
            r_len        <= 4'd0;
            r_size       <= 3'd0;
            r_mode       <= c_MODE_FIXED;
            r_wrap_lower <= '0;
            r_wrap_span  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cmd_fire) begin
                r_valid      <= 1'b1;
                r_id         <= cmd_id;
                r_addr       <= cmd_addr;
                r_idx        <= 4'd0;
                r_last       <= (cmd_len == 4'd0);
                r_err        <= w_cmd_err;
                r_len        <= cmd_len;
                r_size       <= cmd_size;
                r_mode       <= w_cmd_mode;
                r_wrap_lower <= cmd_addr & ~(w_cmd_span - c_ONE);
                r_wrap_span  <= w_cmd_span;
            end else if (w_beat_fire) begin
                if (r_last) begin
                    r_valid <= 1'b0;
                end else begin
                    r_idx  <= r_idx + 4'd1;
                    r_addr <= w_addr_nxt;
                    r_last <= ((r_idx + 4'd1) == r_len);
                end
            end
        end
    end

    assign cmd_ready  = w_cmd_ready;
    assign beat_valid = r_valid;
    assign beat_id    = r_id;
    assign beat_addr  = r_addr;
    assign beat_idx   = r_idx;
    assign beat_last  = r_last;
    assign beat_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_axi3_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi3_burst_addr_gen
// Description : Self-checking bench for axi3_burst_addr_gen. Expected beats
//               come from an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi3_burst_addr_gen;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [IW-1:0] cmd_id;
    logic [AW-1:0] cmd_addr;
    logic [3:0]    cmd_len;
    logic [2:0]    cmd_size;
    logic [1:0]    cmd_burst;
    logic          beat_valid;
    logic          beat_ready;
    logic [IW-1:0] beat_id;
    logic [AW-1:0] beat_addr;
    logic [3:0]    beat_idx;
    logic          beat_last;
    logic          beat_err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Command queued to be offered during the last beat of the current burst
    bit            pend = 0;
    logic [IW-1:0] p_id;
    logic [AW-1:0] p_addr;
    int            p_len, p_size, p_burst;

    axi3_burst_addr_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_id     (cmd_id),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_size   (cmd_size),
        .cmd_burst  (cmd_burst),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_id    (beat_id),
        .beat_addr  (beat_addr),
        .beat_idx   (beat_idx),
        .beat_last  (beat_last),
        .beat_err   (beat_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit wrap_legal(input logic [AW-1:0] a, input int len, input int size);
        int unsigned b = 1 << size;
        return ((len == 1) || (len == 3) || (len == 7) || (len == 15)) && ((a % b) == 0);
    endfunction

    function automatic bit model_err(input logic [AW-1:0] a, input int len, input int size,
                                     input int burst);
        int unsigned b = 1 << size;
        bit e = (burst == 3) || (b > DW / 8) || ((burst == 2) && !wrap_legal(a, len, size));
`ifdef AXI3_BURST_ADDR_GEN_4K_CHECK_EN
        longint unsigned al   = 64'(a - (a % b));
        longint unsigned endb = (al + 64'((len + 1) * b) - 1) % 64'h1_0000_0000;
        if ((burst == 1) && ((endb / 4096) != (al / 4096))) e = 1;
`endif
        return e;
    endfunction

    function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] a, input int len,
                                                 input int size, input int burst, input int n);
        int unsigned   b  = 1 << size;
        logic [AW-1:0] al = a - (a % b);
        int unsigned   span;
        logic [AW-1:0] lower;
        if ((n == 0) || (burst == 0)) return a;
        if ((burst == 2) && wrap_legal(a, len, size)) begin
            span  = b * (len + 1);
            lower = a - (a % span);
            return lower + (((a - lower) + n * b) % span);
        end
        return al + n * b;
    endfunction

    // mode: 0 = always ready, 1 = toggling ready, 2 = random ready
    task automatic run_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                             input int size, input int burst, input int mode, input bit issued);
        int k   = 0;
        int cyc = 0;
        bit rdy;
        bit chained = 0;
        if (!issued) begin
            @(negedge clk);
            cmd_id = id; cmd_addr = addr; cmd_len = 4'(len);
            cmd_size = 3'(size); cmd_burst = 2'(burst);
            cmd_valid = 1'b1; beat_ready = 1'b0;
            #1 chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
            @(posedge clk);
            #1 cmd_valid = 1'b0;
        end
        while ((k <= len) && (cyc < 100)) begin
            @(negedge clk);
            chk("beat_valid", 64'(beat_valid), 64'd1);
            chk("beat_id",    64'(beat_id),    64'(id));
            chk("beat_addr",  64'(beat_addr),  64'(model_addr(addr, len, size, burst, k)));
            chk("beat_idx",   64'(beat_idx),   64'(k));
            chk("beat_last",  64'(beat_last),  64'(k == len));
            chk("beat_err",   64'(beat_err),   64'(model_err(addr, len, size, burst)));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 2) == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            beat_ready = rdy;
            if ((k == len) && rdy && pend) begin
                cmd_id = p_id; cmd_addr = p_addr; cmd_len = 4'(p_len);
                cmd_size = 3'(p_size); cmd_burst = 2'(p_burst);
                cmd_valid = 1'b1;
                chained = 1;
            end
            #1 chk("cmd_ready_busy", 64'(cmd_ready), 64'(rdy && (k == len)));
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            if (rdy) k++;
            cyc++;
        end
        if (cyc >= 100) begin
            n_cmp++;
            n_fail++;
            $error("FAIL burst_timeout: observed %0d beats expected %0d", k, len + 1);
        end
        beat_ready = 1'b0;
        if (!chained) begin
            @(negedge clk);
            chk("beat_valid_idle", 64'(beat_valid), 64'd0);
        end
    endtask

    initial begin
        logic [AW-1:0] ra;
        int            rl, rs, rb;
        rst = 1'b1; cmd_valid = 1'b0; beat_ready = 1'b0;
        cmd_id = '0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_beat_valid", 64'(beat_valid), 64'd0);
        chk("rst_beat_addr",  64'(beat_addr),  64'd0);
        chk("rst_beat_idx",   64'(beat_idx),   64'd0);
        chk("rst_beat_last",  64'(beat_last),  64'd0);
        chk("rst_beat_err",   64'(beat_err),   64'd0);
        chk("rst_cmd_ready",  64'(cmd_ready),  64'd0);
        rst = 1'b0;

        // INCR, legal WRAP, misaligned WRAP, FIXED with stalls
        run_burst(4'd1, 32'h1004, 3, 2, 1, 0, 0);
        run_burst(4'd2, 32'h0038, 3, 3, 2, 0, 0);
        run_burst(4'd3, 32'h003C, 3, 3, 2, 0, 0);
        run_burst(4'd4, 32'h0200, 15, 2, 0, 1, 0);

        // Back-to-back: id 5 is accepted on the last beat of id 6
        pend = 1; p_id = 4'd5; p_addr = 32'h0100; p_len = 2; p_size = 2; p_burst = 1;
        run_burst(4'd6, 32'h0080, 1, 2, 1, 0, 0);
        pend = 0;
        run_burst(4'd5, 32'h0100, 2, 2, 1, 0, 1);

        // 4 KB crossing, reserved burst, oversize beat, WRAP with illegal length
        run_burst(4'd7, 32'h0FF8, 1, 3, 1, 0, 0);
        run_burst(4'd8, 32'h0123, 2, 1, 3, 0, 0);
        run_burst(4'd9, 32'h0400, 1, 4, 1, 0, 0);
        run_burst(4'd10, 32'h0040, 2, 2, 2, 0, 0);

        // Reset during beat 2 of an 8-beat burst
        @(negedge clk);
        cmd_id = 4'd11; cmd_addr = 32'h0400; cmd_len = 4'd7; cmd_size = 3'd2; cmd_burst = 2'd1;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0; beat_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_idx_before_rst", 64'(beat_idx), 64'd2);
        rst = 1'b1;
        #1 chk("rst_cmd_ready_comb", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        chk("mid_rst_beat_valid", 64'(beat_valid), 64'd0);
        chk("mid_rst_beat_addr",  64'(beat_addr),  64'd0);
        chk("mid_rst_cmd_ready",  64'(cmd_ready),  64'd0);
        rst = 1'b0; beat_ready = 1'b0;
        run_burst(4'd12, 32'h0800, 2, 2, 1, 0, 0);

        // Randomised bursts under random backpressure
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rl = $urandom_range(0, 15);
            rs = $urandom_range(0, 4);
            rb = $urandom_range(0, 3);
            if ((rb == 2) && ($urandom_range(0, 2) != 0)) begin
                rl = (2 << $urandom_range(0, 3)) - 1;
                ra = ra & ~((32'd1 << rs) - 32'd1);
            end
            run_burst(4'($urandom), ra, rl, rs, rb, 2, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
